key_operand_loader: RTL and testbench

KEY_OPERAND_LOADER -- requirements
Module: key_operand_loader

---
 rtl/key_operand_loader_if.sv | 31 +++
 rtl/key_operand_loader.sv | 115 +++++++++++
 tb/tb_key_operand_loader.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/key_operand_loader_if.sv
// key_operand_loader_if
// Bundles the keypad-in and operand-out signals of the key operand loader.
//   key_code/key_valid : decoded keypad strobe from the scanner
//   op_a/op_b/op_valid/op_ready : committed BCD operand pair and its handshake
//   disp_val/phase/ovf : entry value, entry phase, sticky overflow
// master: the loader side. slave: the keypad/adder/display side.
interface key_operand_loader_if #(
    parameter int unsigned NDIG = 3
);
    localparam int unsigned W = 4 * NDIG;

    logic [3:0]   key_code;
    logic         key_valid;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         op_valid;
    logic         op_ready;
    logic [W-1:0] disp_val;
    logic         phase;
    logic         ovf;

    modport master (
        input  key_code, key_valid, op_ready,
        output op_a, op_b, op_valid, disp_val, phase, ovf
    );

    modport slave (
        output key_code, key_valid, op_ready,
        input  op_a, op_b, op_valid, disp_val, phase, ovf
    );
endinterface

// File: rtl/key_operand_loader.sv
// key_operand_loader
// Collects keypad digits into two packed-BCD operands A and B and offers the pair
// to a downstream adder with a valid/ready handshake.
//   clk : clock, rising edge
//   rst : synchronous active-low reset
//   bus : key_operand_loader_if.master (keys in, operands/display/status out)
// Keys: 0-9 digit, 10 '+' commits A, 11 '=' commits B and issues, 12 clear, 13-15 ignored.
module key_operand_loader #(
    parameter int unsigned NDIG = 3
) (
    input logic                  clk,
    input logic                  rst,
    key_operand_loader_if.master bus
);
    localparam int unsigned W    = 4 * NDIG;
    localparam int unsigned CntW = $clog2(NDIG + 1);

    typedef enum logic [1:0] {StEnterA, StEnterB, StIssue} state_e;

    state_e          state_q, state_d;
    logic [W-1:0]    entry_q, entry_d;
    logic [W-1:0]    op_a_q, op_a_d;
    logic [W-1:0]    op_b_q, op_b_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            ovf_q, ovf_d;

    logic key_digit, key_add, key_eq, key_clr, handshake;

    assign key_digit = bus.key_valid && (bus.key_code <= 4'd9);
    assign key_add   = bus.key_valid && (bus.key_code == 4'd10);
    assign key_eq    = bus.key_valid && (bus.key_code == 4'd11);
    assign key_clr   = bus.key_valid && (bus.key_code == 4'd12);
    // op_valid is exactly "in ISSUE", so the handshake is qualified by state.
    assign handshake = (state_q == StIssue) && bus.op_ready;

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= StEnterA;
            entry_q <= '0;
            op_a_q  <= '0;
            op_b_q  <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            entry_q <= entry_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    // Next-state and datapath
    always_comb begin
        state_d = state_q;
        entry_d = entry_q;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;

        if (key_clr) begin
            // Clear wins over everything, including a same-cycle handshake.
            state_d = StEnterA;
            entry_d = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
        end else begin
            unique case (state_q)
                StEnterA, StEnterB: begin
                    if (key_digit) begin
                        if (cnt_q < CntW'(NDIG)) begin
                            // Shift left one digit; the top digit falls off only when
                            // the entry was already full, which this branch excludes.
                            entry_d = (entry_q << 4) | W'(bus.key_code);
                            cnt_d   = cnt_q + CntW'(1);
                        end else begin
                            ovf_d = 1'b1;
                        end
                    end else if (key_add && state_q == StEnterA) begin
                        op_a_d  = entry_q;
                        entry_d = '0;
                        cnt_d   = '0;
                        ovf_d   = 1'b0;
                        state_d = StEnterB;
                    end else if (key_eq && state_q == StEnterB) begin
                        op_b_d  = entry_q;
                        entry_d = '0;
                        cnt_d   = '0;
                        ovf_d   = 1'b0;
                        state_d = StIssue;
                    end
                end
                StIssue: begin
                    if (handshake) begin
                        state_d = StEnterA;
                    end
                end
                default: state_d = StEnterA;
            endcase
        end
    end

    // Outputs
    always_comb begin
        bus.op_a     = op_a_q;
        bus.op_b     = op_b_q;
        bus.op_valid = (state_q == StIssue);
        bus.disp_val = entry_q;
        bus.phase    = (state_q != StEnterA);
        bus.ovf      = ovf_q;
    end
endmodule

// File: tb/tb_key_operand_loader.sv
// tb_key_operand_loader
// Directed scenarios plus a randomized run, all compared against a digit-list
// reference model of the keypad calculator front end.
module tb_key_operand_loader;
    localparam int unsigned NDIG = 3;
    localparam int unsigned W    = 4 * NDIG;
    localparam int unsigned VW   = 3 * W + 3;

    logic clk;
    logic rst;

    key_operand_loader_if #(.NDIG(NDIG)) bus ();

    key_operand_loader #(.NDIG(NDIG)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: digits entered so far, committed operands, stage 0/1/2
    int unsigned m_digits[$];
    logic [W-1:0] m_a, m_b;
    int           m_stage;
    bit           m_ovf;

    function automatic logic [W-1:0] pack_entry();
        logic [W-1:0] v = '0;
        foreach (m_digits[i]) v = (v << 4) | W'(m_digits[i]);
        return v;
    endfunction

    function automatic logic [VW-1:0] exp_vec();
        return {m_a, m_b, (m_stage == 2), pack_entry(), (m_stage != 0), m_ovf};
    endfunction

    function automatic logic [VW-1:0] got_vec();
        return {bus.op_a, bus.op_b, bus.op_valid, bus.disp_val, bus.phase, bus.ovf};
    endfunction

    task automatic model_step();
        bit ready_seen = (m_stage == 2) && bus.op_ready;
        if (!rst) begin
            m_digits.delete();
            m_a = '0; m_b = '0; m_stage = 0; m_ovf = 1'b0;
        end else if (bus.key_valid && bus.key_code == 4'd12) begin
            m_digits.delete();
            m_ovf = 1'b0; m_stage = 0;
        end else if (m_stage == 2) begin
            if (ready_seen) m_stage = 0;
        end else if (bus.key_valid && bus.key_code <= 4'd9) begin
            if (m_digits.size() < NDIG) m_digits.push_back(int'(bus.key_code));
            else m_ovf = 1'b1;
        end else if (bus.key_valid && bus.key_code == 4'd10 && m_stage == 0) begin
            m_a = pack_entry(); m_digits.delete(); m_ovf = 1'b0; m_stage = 1;
        end else if (bus.key_valid && bus.key_code == 4'd11 && m_stage == 1) begin
            m_b = pack_entry(); m_digits.delete(); m_ovf = 1'b0; m_stage = 2;
        end
    endtask

    // Advance one clock with the currently driven inputs, then sample at +1.
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic press(input logic [3:0] code);
        bus.key_valid = 1'b1;
        bus.key_code  = code;
        tick();
        bus.key_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; bus.key_valid = 1'b1; bus.key_code = 4'd5; bus.op_ready = 1'b1;
        tick();
        bus.key_valid = 1'b0;
        checks++;
        if (got_vec() !== {VW{1'b0}}) begin
            errors++;
            $display("FAIL reset_zero: got %h expected %h", got_vec(), {VW{1'b0}});
        end
        rst = 1'b1;
        tick();
        checks++;
        if (got_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL reset_idle: got %h expected %h", got_vec(), exp_vec());
        end
    endtask

    task automatic test_basic_pair();
        logic [3:0] seq[7] = '{4'd1, 4'd2, 4'd3, 4'd10, 4'd4, 4'd5, 4'd11};
        bus.op_ready = 1'b1;
        foreach (seq[i]) press(seq[i]);
        checks++;
        if ({bus.op_valid, bus.op_a, bus.op_b} !== {1'b1, 12'h123, 12'h045}) begin
            errors++;
            $display("FAIL basic_issue: got v=%b a=%h b=%h expected v=1 a=123 b=045",
                     bus.op_valid, bus.op_a, bus.op_b);
        end
        tick();
        checks++;
        if ({bus.op_valid, bus.phase, bus.op_a, bus.op_b} !== {2'b00, 12'h123, 12'h045}) begin
            errors++;
            $display("FAIL basic_after_hs: got v=%b ph=%b a=%h b=%h expected v=0 ph=0 a=123 b=045",
                     bus.op_valid, bus.phase, bus.op_a, bus.op_b);
        end
    endtask

    task automatic test_overflow();
        logic [3:0] seq[4] = '{4'd9, 4'd8, 4'd7, 4'd6};
        foreach (seq[i]) press(seq[i]);
        checks++;
        if ({bus.disp_val, bus.ovf} !== {12'h987, 1'b1}) begin
            errors++;
            $display("FAIL ovf_set: got disp=%h ovf=%b expected disp=987 ovf=1",
                     bus.disp_val, bus.ovf);
        end
        press(4'd10);
        checks++;
        if ({bus.op_a, bus.ovf, bus.phase} !== {12'h987, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL ovf_commit: got a=%h ovf=%b ph=%b expected a=987 ovf=0 ph=1",
                     bus.op_a, bus.ovf, bus.phase);
        end
        press(4'd12);
    endtask

    task automatic test_hold();
        int held = 0;
        bus.op_ready = 1'b0;
        press(4'd10);
        press(4'd11);
        for (int i = 0; i < 5; i++) begin
            if (bus.op_valid === 1'b1 && bus.op_a === 12'h0 && bus.op_b === 12'h0) held++;
            if (i < 4) tick();
        end
        checks++;
        if (held != 5) begin
            errors++;
            $display("FAIL hold_valid: got %0d cycles expected 5", held);
        end
        bus.op_ready = 1'b1;
        tick();
        checks++;
        if ({bus.op_valid, bus.phase} !== 2'b00) begin
            errors++;
            $display("FAIL hold_drop: got v=%b ph=%b expected v=0 ph=0", bus.op_valid, bus.phase);
        end
    endtask

    task automatic test_clear();
        press(4'd5); press(4'd10); press(4'd7); press(4'd12);
        checks++;
        if ({bus.phase, bus.disp_val, bus.op_a} !== {1'b0, 12'h000, 12'h005}) begin
            errors++;
            $display("FAIL clear: got ph=%b disp=%h a=%h expected ph=0 disp=000 a=005",
                     bus.phase, bus.disp_val, bus.op_a);
        end
        press(4'd11);
        checks++;
        if (got_vec() !== exp_vec() || bus.phase !== 1'b0 || bus.op_valid !== 1'b0) begin
            errors++;
            $display("FAIL eq_ignored_in_a: got %h expected %h", got_vec(), exp_vec());
        end
    endtask

    task automatic test_issue_ignore_reset();
        logic [VW-1:0] snap;
        bus.op_ready = 1'b0;
        press(4'd2); press(4'd10); press(4'd6); press(4'd11);
        snap = got_vec();
        press(4'd3); press(4'd13); press(4'd10); press(4'd11);
        checks++;
        if (got_vec() !== snap || snap !== exp_vec()) begin
            errors++;
            $display("FAIL issue_ignore: got %h expected %h", got_vec(), exp_vec());
        end
        rst = 1'b0; bus.op_ready = 1'b1;
        tick();
        rst = 1'b1;
        checks++;
        if (got_vec() !== {VW{1'b0}}) begin
            errors++;
            $display("FAIL issue_reset: got %h expected %h", got_vec(), {VW{1'b0}});
        end
    endtask

    task automatic test_clear_handshake();
        bus.op_ready = 1'b0;
        press(4'd10); press(4'd4); press(4'd11);
        bus.op_ready = 1'b1;
        press(4'd12);
        checks++;
        if ({bus.op_valid, bus.phase, bus.op_b} !== {2'b00, 12'h004}) begin
            errors++;
            $display("FAIL clear_hs: got v=%b ph=%b b=%h expected v=0 ph=0 b=004",
                     bus.op_valid, bus.phase, bus.op_b);
        end
    endtask

    task automatic test_back_to_back();
        press(4'd12);
        press(4'd1); press(4'd2);
        checks++;
        if (bus.disp_val !== 12'h012) begin
            errors++;
            $display("FAIL back_to_back: got disp=%h expected 012", bus.disp_val);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            int unsigned r = $urandom_range(0, 99);
            rst           = ($urandom_range(0, 99) != 0);
            bus.op_ready  = ($urandom_range(0, 2) == 0);
            bus.key_valid = (r < 70);
            if (r < 40)      bus.key_code = 4'($urandom_range(0, 9));
            else if (r < 52) bus.key_code = 4'd10;
            else if (r < 64) bus.key_code = 4'd11;
            else if (r < 67) bus.key_code = 4'd12;
            else             bus.key_code = 4'($urandom_range(13, 15));
            tick();
            checks++;
            if (got_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL random[%0d]: got %h expected %h", i, got_vec(), exp_vec());
            end
        end
        rst = 1'b1; bus.key_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; bus.key_valid = 1'b0; bus.key_code = 4'd0; bus.op_ready = 1'b0;
        m_a = '0; m_b = '0; m_stage = 0; m_ovf = 1'b0;
        @(negedge clk);
        test_reset();
        test_basic_pair();
        test_overflow();
        test_hold();
        test_clear();
        test_issue_ignore_reset();
        test_clear_handshake();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
